// File: rtl/fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_if
// Request/status bundle between the FIFO top and its pointer/occupancy
// controller (fifo_ctrl).
//
// Parameters
//   DEPTH : number of register entries (power of two, >= 2)
//   AW    : pointer width, log2(DEPTH)
//
// Signals
//   wr_en, rd_en        : per-cycle write / read requests (top -> ctrl)
//   wr_sel[DEPTH]       : one-hot register-entry write enable (ctrl -> top)
//   rd_addr[AW]         : registered read-mux select (ctrl -> top)
//   data_count[AW+1]    : occupancy 0..DEPTH
//   full, empty         : occupancy flags
//   wr_ack, wr_err      : write accepted / rejected (cycle after request)
//   rd_ack, rd_err      : read accepted / rejected (cycle after request)
//   almost_full/empty   : only when FIFO_CTRL_ALMOST_EN is defined
//
// Modports
//   master : FIFO top side (drives requests)
//   slave  : controller side (drives selects and status)
// -----------------------------------------------------------------------------
interface fifo_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
);
    logic             wr_en;
    logic             rd_en;
    logic [DEPTH-1:0] wr_sel;
    logic [AW-1:0]    rd_addr;
    logic [AW:0]      data_count;
    logic             full;
    logic             empty;
    logic             wr_ack;
    logic             wr_err;
    logic             rd_ack;
    logic             rd_err;
`ifdef FIFO_CTRL_ALMOST_EN
    logic             almost_full;
    logic             almost_empty;
`endif

    modport master (
        output wr_en,
        output rd_en,
        input  wr_sel,
        input  rd_addr,
        input  data_count,
        input  full,
        input  empty,
        input  wr_ack,
        input  wr_err,
        input  rd_ack,
`ifdef FIFO_CTRL_ALMOST_EN
        input  almost_full,
        input  almost_empty,
`endif
        input  rd_err
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        output wr_sel,
        output rd_addr,
        output data_count,
        output full,
        output empty,
        output wr_ack,
        output wr_err,
        output rd_ack,
`ifdef FIFO_CTRL_ALMOST_EN
        output almost_full,
        output almost_empty,
`endif
        output rd_err
    );
endinterface

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer, occupancy and status controller for a DEPTH-entry register-file
// FIFO. Holds no data: it drives the one-hot write enables of the register
// bank and the registered select of the output read mux.
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous assert, synchronously released, active-low reset
//   bus      : fifo_ctrl_if.slave (requests in; wr_sel, rd_addr, count,
//              full/empty and ack/err status out)
//
// Optional feature
//   FIFO_CTRL_ALMOST_EN : when defined, adds almost_full (count == DEPTH-1)
//                         and almost_empty (count == 1) to the interface.
//
// Behaviour summary
//   - A write is accepted when wr_en & ~rd_en & ~full; wr_sel is the one-hot
//     of the tail pointer in that same cycle so the entry captures on the edge.
//   - A read is accepted when rd_en & ~wr_en & ~empty; rd_addr registers the
//     head pointer so mux data is valid in the cycle rd_ack is high.
//   - Simultaneous requests are ignored (NO_OP).
//   - ack/err are Moore outputs of the state, one cycle after the request.
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    fifo_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_NO_OP    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WR_ERROR = 3'd3,
        ST_READ     = 3'd4,
        ST_RD_ERROR = 3'd5
    } state_t;

    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    state_t          state_reg,   state_next;
    logic [AW-1:0]   head_reg,    head_next;
    logic [AW-1:0]   tail_reg,    tail_next;
    logic [AW:0]     count_reg,   count_next;
    logic [AW-1:0]   rd_addr_reg, rd_addr_next;

    logic            wr_req;
    logic            rd_req;
    logic            wr_accept;
    logic            rd_accept;
    logic            full_w;
    logic            empty_w;
    logic [DEPTH-1:0] wr_sel_w;

    logic            wr_ack_w;
    logic            wr_err_w;
    logic            rd_ack_w;
    logic            rd_err_w;

    // Occupancy flags come straight from the count register, so they show
    // the post-edge occupancy and fall to their reset values as soon as the
    // asynchronous reset clears the count.
    assign full_w  = (count_reg == COUNT_FULL);
    assign empty_w = (count_reg == '0);

    // Only a lone request is considered; both-at-once is a no-op.
    assign wr_req = bus.wr_en & ~bus.rd_en;
    assign rd_req = bus.rd_en & ~bus.wr_en;

    // reset_n gates the write enable so no register entry can be written
    // while reset is held, even if wr_en is high.
    assign wr_accept = wr_req & ~full_w & reset_n;
    assign rd_accept = rd_req & ~empty_w;

    // One-hot decode of the tail pointer into per-entry write enables.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel_w[gi] = wr_accept & (tail_reg == AW'(gi));
        end
    endgenerate

    // State and pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_INIT;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            rd_addr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            count_reg   <= count_next;
            rd_addr_reg <= rd_addr_next;
        end
    end

    // Next-state, pointer updates and Moore status decode.
    always_comb begin
        state_next   = ST_NO_OP;
        head_next    = head_reg;
        tail_next    = tail_reg;
        count_next   = count_reg;
        rd_addr_next = rd_addr_reg;
        wr_ack_w     = 1'b0;
        wr_err_w     = 1'b0;
        rd_ack_w     = 1'b0;
        rd_err_w     = 1'b0;

        if (wr_req) begin
            state_next = full_w ? ST_WR_ERROR : ST_WRITE;
        end else if (rd_req) begin
            state_next = empty_w ? ST_RD_ERROR : ST_READ;
        end

        // Pointers wrap by natural AW-bit overflow; accept conditions keep
        // the count inside 0..DEPTH.
        if (wr_accept) begin
            tail_next  = tail_reg + AW'(1);
            count_next = count_reg + (AW+1)'(1);
        end else if (rd_accept) begin
            rd_addr_next = head_reg;
            head_next    = head_reg + AW'(1);
            count_next   = count_reg - (AW+1)'(1);
        end

        unique case (state_reg)
            ST_WRITE:    wr_ack_w = 1'b1;
            ST_WR_ERROR: wr_err_w = 1'b1;
            ST_READ:     rd_ack_w = 1'b1;
            ST_RD_ERROR: rd_err_w = 1'b1;
            default:     ;
        endcase
    end

    assign bus.wr_sel     = wr_sel_w;
    assign bus.rd_addr    = rd_addr_reg;
    assign bus.data_count = count_reg;
    assign bus.full       = full_w;
    assign bus.empty      = empty_w;
    assign bus.wr_ack     = wr_ack_w;
    assign bus.wr_err     = wr_err_w;
    assign bus.rd_ack     = rd_ack_w;
    assign bus.rd_err     = rd_err_w;

`ifdef FIFO_CTRL_ALMOST_EN
    assign bus.almost_full  = (count_reg == COUNT_FULL - (AW+1)'(1));
    assign bus.almost_empty = (count_reg == (AW+1)'(1));
`endif

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control block for the 8-entry, 32-bit register-file FIFO. It tracks head and tail pointers and occupancy. It drives the per-entry write enables of the 32-bit enable-registers and the read-select address of the output mux, and reports full/empty and per-request ack/error status. It holds no data itself; the FIFO top instantiates it beside the register bank and read mux.

## Interface
- DEPTH, 8, number of register entries (power of two, ≥2)
- AW, 3, pointer width, log2(DEPTH)
- clk  input  1  rising-edge clock
- reset_n  input  1  reset, asynchronous, active-low
- wr_en  input  1  write request for this cycle
- rd_en  input  1  read request for this cycle
- wr_sel  output  DEPTH  one-hot write enable, bit i drives the en of register entry i
- rd_addr  output  AW  read-mux select, registered
- data_count  output  AW+1  current occupancy, 0..DEPTH
- full  output  1  data_count == DEPTH
- empty  output  1  data_count == 0
- wr_ack / wr_err  output  1 each  write accepted / write rejected (full)
- rd_ack / rd_err  output  1 each  read accepted / read rejected (empty)

## Operation
- State register with six states: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR.
- Next state is evaluated every cycle from wr_en, rd_en and the current data_count:
  - wr_en=1, rd_en=0: WR_ERROR if full, else WRITE.
  - rd_en=1, wr_en=0: RD_ERROR if empty, else READ.
  - Both 0 or both 1: NO_OP. A simultaneous request is ignored; no pointer or count change and no ack/err.
- INIT occurs only in reset and is left on the first clock after reset release.
- Accepted write, issued in the cycle the request is seen: wr_sel = one-hot(tail), combinational from wr_en & ~rd_en & ~full. The entry captures d_in on that edge. tail <= tail+1 and count <= count+1.
- Accepted read: rd_addr <= head, then head <= head+1 and count <= count-1.
- Pointers wrap modulo DEPTH (AW-bit natural overflow). count never exceeds DEPTH or goes below 0.
- Rejected requests leave head, tail, count, rd_addr and all entries unchanged; wr_sel stays all-zero.
- wr_sel is all-zero whenever no write is accepted, including during reset.

## Timing
- Reset (async assert, sync release) sets state=INIT, head=tail=0, count=0 and rd_addr=0. During reset: wr_sel=0, full=0, empty=1, all ack/err=0.
- Reset asserted mid-operation: all of the above apply immediately. The register contents are cleared by their own reset.
- Status outputs are Moore outputs of the state, valid in the cycle after the request:
  - WRITE → wr_ack=1; WR_ERROR → wr_err=1; READ → rd_ack=1; RD_ERROR → rd_err=1.
  - INIT and NO_OP → all 0.
- Read latency 1: data at the mux output is valid in the cycle rd_ack=1.
- full, empty and data_count are combinational from the count register and reflect the post-edge count.
- Back-to-back requests are allowed every cycle. Throughput is one operation per cycle.

## Configuration
- FIFO_CTRL_ALMOST_EN defined: adds outputs almost_full (data_count == DEPTH-1) and almost_empty (data_count == 1). Both are 1-bit and combinational from count, and both are 0 in reset.
- Not defined: these ports do not exist; all other behaviour is identical.

## Test plan
- Reset then idle 3 cycles -> empty=1, full=0, data_count=0, rd_addr=0, wr_sel=0, all ack/err=0.
- 8 consecutive writes from empty -> wr_sel walks 0x01..0x80, wr_ack=1 on each following cycle, full=1 and data_count=8 after the 8th. A 9th write -> wr_err=1, wr_sel=0, count stays 8.
- 8 reads after fill -> rd_addr 0..7 with rd_ack each cycle, empty=1 after the last. A 9th read -> rd_err=1, rd_addr holds 7.
- Wrap: write 5, read 5, write 6 -> wr_sel 0x20,0x40,0x80,0x01,0x02,0x04, data_count=6. Reading 6 gives rd_addr 5,6,7,0,1,2.
- wr_en=rd_en=1 with count=3 -> NO_OP, count stays 3, no ack/err, wr_sel=0.
- Assert reset_n=0 with count=4 mid-burst -> count=0, empty=1, wr_sel=0 without a clock edge. With FIFO_CTRL_ALMOST_EN: almost_full=1 at count 7, almost_empty=1 at count 1.
